// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 sequencer state encodings, funct3 codes and reset vector
package riscv_pkg;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    HALT = 3'd4
  } seq_state_e;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Instruction fetch requires word alignment; any set low bit is a trap.
  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction memory request/response port
interface pc_sequencer_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid
  );

endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// rtl/pc_sequencer_branch_cond.sv - combinational branch/jump taken decision
module branch_cond
  import riscv_pkg::*;
(
  input  logic       branch,
  input  logic       jump,
  input  logic [2:0] funct3,
  input  logic       ZF,
  input  logic       SF,
  output logic       taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = ZF;
      F3_BNE:  cond = ~ZF;
      F3_BLT:  cond = SF;
      default: cond = 1'b0;
    endcase
  end

  // A jump is unconditional, so it wins regardless of the branch decode.
  assign taken = jump | (branch & cond);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/wait/execute sequencer owning the PC and perf counters
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.master    imem,
  output logic              instr_valid,
  input  logic              ex_done,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              ZF,
  input  logic              SF,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   target,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              redirect,
  output logic              misalign_trap,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  seq_state_e       state_q, state_d;
  logic [XLEN-1:0]  pc_q;
  logic             trap_q;
  logic [CNT_W-1:0] retired_q, taken_q;

  logic taken;
  logic accept;
  logic retire;
  logic trap_set;

  branch_cond u_branch_cond (
    .branch (branch),
    .jump   (jump),
    .funct3 (funct3),
    .ZF     (ZF),
    .SF     (SF),
    .taken  (taken)
  );

  // ex_done is only honoured in EXEC; while stalled the datapath keeps it asserted.
  assign accept = (state_q == EXEC) && ex_done && !stall;

  always_comb begin
    state_d             = state_q;
    imem.imem_req_valid = 1'b0;
    instr_valid         = 1'b0;
    redirect            = 1'b0;
    retire              = 1'b0;
    trap_set            = 1'b0;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        imem.imem_req_valid = 1'b1;
        if (imem.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          instr_valid = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (accept) begin
          if (taken && misaligned(target[1:0])) begin
            trap_set = 1'b1;
            state_d  = HALT;
          end else begin
            retire   = 1'b1;
            redirect = taken;
            state_d  = REQ;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      trap_q    <= 1'b0;
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) pc_q <= taken ? target : pc_plus4;
      if (trap_set) trap_q <= 1'b1;
      if (retire && (retired_q != '1)) retired_q <= retired_q + CNT_W'(1);
      if (redirect && (taken_q != '1)) taken_q <= taken_q + CNT_W'(1);
    end
  end

  assign pc             = pc_q;
  assign pc_plus4       = pc_q + XLEN'(4);
  assign imem.imem_addr = pc_q;
  assign misalign_trap  = trap_q;
  assign retired_cnt    = retired_q;
  assign taken_cnt      = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer fetch/branch/trap sequencing
module tb_pc_sequencer;
  import riscv_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(XLEN)) imem ();

  logic             instr_valid;
  logic             ex_done, stall, branch, jump, ZF, SF;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  target, pc, pc_plus4;
  logic             redirect, misalign_trap;
  logic [CNT_W-1:0] retired_cnt, taken_cnt;

  pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem),
    .instr_valid   (instr_valid),
    .ex_done       (ex_done),
    .stall         (stall),
    .branch        (branch),
    .jump          (jump),
    .ZF            (ZF),
    .SF            (SF),
    .funct3        (funct3),
    .target        (target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect),
    .misalign_trap (misalign_trap),
    .retired_cnt   (retired_cnt),
    .taken_cnt     (taken_cnt)
  );

  int          compared = 0;
  int          mismatched = 0;
  int          redirect_seen = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted fetch must match the next expected address.
  always @(negedge clk) begin
    if (!rst && imem.imem_req_valid && imem.imem_req_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem.imem_addr);
      end else begin
        chk("fetch_addr", imem.imem_addr, exp_q.pop_front());
      end
    end
    if (!rst && redirect) redirect_seen++;
  end

  task automatic check_reset();
    @(negedge clk);
    chk("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
    chk("rst_pc", pc, RV);
    chk("rst_retired", 32'(retired_cnt), 32'd0);
    chk("rst_taken", 32'(taken_cnt), 32'd0);
    chk("rst_trap", 32'(misalign_trap), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
  endtask

  task automatic fetch(input logic [31:0] exp_addr, input int ready_delay, input logic give_rsp);
    int n;
    exp_q.push_back(exp_addr);
    n = 0;
    @(negedge clk);
    while (!imem.imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
    repeat (ready_delay) begin
      @(negedge clk);
      chk("req_hold", 32'(imem.imem_req_valid), 32'd1);
    end
    @(posedge clk); #1 imem.imem_req_ready = 1'b1;
    @(posedge clk); #1 imem.imem_req_ready = 1'b0;
    if (give_rsp) begin
      imem.imem_rsp_valid = 1'b1;
      @(negedge clk);
      chk("instr_valid", 32'(instr_valid), 32'd1);
      @(posedge clk); #1 imem.imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [31:0] cur, input logic br, input logic jp,
                           input logic [2:0] f3, input logic zf, input logic sf,
                           input logic [31:0] tgt, input int stall_n, input int ready_delay,
                           input logic exp_redirect, input logic [31:0] exp_next);
    fetch(cur, ready_delay, 1'b1);
    branch = br; jump = jp; funct3 = f3; ZF = zf; SF = sf; target = tgt;
    ex_done = 1'b1;
    stall = (stall_n > 0);
    repeat (stall_n) begin
      @(negedge clk);
      chk("stall_pc", pc, cur);
      chk("stall_redirect", 32'(redirect), 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    chk("redirect", 32'(redirect), 32'(exp_redirect));
    @(posedge clk); #1;
    ex_done = 1'b0; branch = 1'b0; jump = 1'b0; ZF = 1'b0; SF = 1'b0;
    funct3 = 3'b000; target = '0;
    chk("pc_next", pc, exp_next);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int halt_reqs;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    ex_done = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    ZF = 1'b0; SF = 1'b0; funct3 = 3'b000; target = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset();

    // Sequential fetch from the reset vector
    run_instr(32'h0, 0, 0, 3'b000, 0, 0, 32'h0,   0, 0, 0, 32'h4);
    run_instr(32'h4, 0, 0, 3'b000, 0, 0, 32'h0,   0, 0, 0, 32'h8);
    run_instr(32'h8, 0, 0, 3'b000, 0, 0, 32'h0,   0, 0, 0, 32'hC);
    chk("retired_after_3", 32'(retired_cnt), 32'd3);
    chk("no_redirect_seq", 32'(redirect_seen), 32'd0);
    run_instr(32'hC, 0, 0, 3'b000, 0, 0, 32'h0,   0, 0, 0, 32'h10);

    // BEQ taken / not taken, JAL back, then BNE, BLT, invalid funct3, jump priority
    run_instr(32'h10,  1, 0, 3'b000, 1, 0, 32'h40,  0, 0, 1, 32'h40);
    chk("taken_after_beq", 32'(taken_cnt), 32'd1);
    run_instr(32'h40,  1, 0, 3'b000, 0, 0, 32'h80,  0, 0, 0, 32'h44);
    run_instr(32'h44,  0, 1, 3'b000, 0, 0, 32'h10,  0, 0, 1, 32'h10);
    run_instr(32'h10,  1, 0, 3'b000, 0, 0, 32'h40,  0, 0, 0, 32'h14);
    run_instr(32'h14,  1, 0, 3'b001, 0, 0, 32'h200, 0, 0, 1, 32'h200);
    run_instr(32'h200, 1, 0, 3'b100, 0, 1, 32'h300, 0, 0, 1, 32'h300);
    run_instr(32'h300, 1, 0, 3'b111, 1, 1, 32'h400, 0, 0, 0, 32'h304);
    run_instr(32'h304, 1, 0, 3'b001, 1, 0, 32'h500, 0, 0, 0, 32'h308);
    run_instr(32'h308, 1, 1, 3'b000, 0, 0, 32'h600, 0, 0, 1, 32'h600);
    chk("retired_before_stall", 32'(retired_cnt), 32'd13);

    // Stall held for five cycles with ex_done asserted
    run_instr(32'h600, 0, 0, 3'b000, 0, 0, 32'h0, 5, 0, 0, 32'h604);
    chk("retired_after_stall", 32'(retired_cnt), 32'd14);
    chk("taken_total", 32'(taken_cnt), 32'd5);

    // Misaligned jump traps into HALT with the PC held
    run_instr(32'h604, 0, 1, 3'b000, 0, 0, 32'h102, 0, 0, 0, 32'h604);
    chk("trap_set", 32'(misalign_trap), 32'd1);
    chk("trap_no_retire", 32'(retired_cnt), 32'd14);
    chk("trap_no_taken", 32'(taken_cnt), 32'd5);
    halt_reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem.imem_req_valid) halt_reqs++;
    end
    chk("halt_no_req", 32'(halt_reqs), 32'd0);
    chk("trap_sticky", 32'(misalign_trap), 32'd1);

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset();

    // Wrap-around from the top of the address space, with a slow imem
    run_instr(32'h0, 0, 1, 3'b000, 0, 0, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC);
    run_instr(32'hFFFF_FFFC, 0, 0, 3'b000, 0, 0, 32'h0, 0, 4, 0, 32'h0);
    chk("retired_after_wrap", 32'(retired_cnt), 32'd2);

    // Reset while waiting for the instruction word
    fetch(32'h0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset();
    run_instr(32'h0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 32'h4);
    chk("retired_after_rst", 32'(retired_cnt), 32'd1);

    chk("redirect_total", 32'(redirect_seen), 32'd6);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
